// File: rtl/alu_wb_stage.sv
// Writeback stage after the ALU. A 2-entry skid buffer feeds the register-file
// write port over valid/ready. The stage also owns the architectural carry/zero
// flags and forwards the youngest pending write.
module alu_wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_carry,
    input  logic              in_zero,
    input  logic [RA_W-1:0]   in_rd,
    input  logic              in_wr_en,
    input  logic              in_flags_en,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RA_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              flag_carry,
    output logic              flag_zero,
    output logic              fwd_valid,
    output logic [RA_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [15:0]       retired
);

    localparam int unsigned RET_W = 16;

    // Head entry (drives out_*) and skid entry
    logic              r_h_valid;
    logic [RA_W-1:0]   r_h_rd;
    logic [DATA_W-1:0] r_h_data;
    logic              r_s_valid;
    logic [RA_W-1:0]   r_s_rd;
    logic [DATA_W-1:0] r_s_data;

    logic              r_in_ready;
    logic              r_flag_carry;
    logic              r_flag_zero;
    logic [RET_W-1:0]  r_retired;
    logic [RA_W-1:0]   r_fwd_rd;
    logic [DATA_W-1:0] r_fwd_data;

    logic              w_accept;
    logic              w_retire;
    logic              w_enq;
    logic              w_h_valid_nxt;
    logic [RA_W-1:0]   w_h_rd_nxt;
    logic [DATA_W-1:0] w_h_data_nxt;
    logic              w_s_valid_nxt;
    logic [RA_W-1:0]   w_s_rd_nxt;
    logic [DATA_W-1:0] w_s_data_nxt;
    logic [RA_W-1:0]   w_fwd_rd_nxt;
    logic [DATA_W-1:0] w_fwd_data_nxt;

    assign w_accept = in_valid && r_in_ready && !flush;
    assign w_retire = r_h_valid && out_ready;
    assign w_enq    = w_accept && in_wr_en;

    // Next buffer contents: retire shifts S into H, a new beat fills the first free slot behind
    always_comb begin
        w_h_valid_nxt = r_h_valid;
        w_h_rd_nxt    = r_h_rd;
        w_h_data_nxt  = r_h_data;
        w_s_valid_nxt = r_s_valid;
        w_s_rd_nxt    = r_s_rd;
        w_s_data_nxt  = r_s_data;

        if (flush) begin
            w_h_valid_nxt = 1'b0;
            w_s_valid_nxt = 1'b0;
        end else begin
            if (w_retire) begin
                if (r_s_valid) begin
                    w_h_valid_nxt = 1'b1;
                    w_h_rd_nxt    = r_s_rd;
                    w_h_data_nxt  = r_s_data;
                    w_s_valid_nxt = 1'b0;
                end else begin
                    w_h_valid_nxt = 1'b0;
                end
            end
            if (w_enq) begin
                if (!r_h_valid || (w_retire && !r_s_valid)) begin
                    w_h_valid_nxt = 1'b1;
                    w_h_rd_nxt    = in_rd;
                    w_h_data_nxt  = in_result;
                end else begin
                    w_s_valid_nxt = 1'b1;
                    w_s_rd_nxt    = in_rd;
                    w_s_data_nxt  = in_result;
                end
            end
        end
    end

    // Youngest pending write after this edge; holds when the buffer drains
    always_comb begin
        w_fwd_rd_nxt   = r_fwd_rd;
        w_fwd_data_nxt = r_fwd_data;
        if (w_s_valid_nxt) begin
            w_fwd_rd_nxt   = w_s_rd_nxt;
            w_fwd_data_nxt = w_s_data_nxt;
        end else if (w_h_valid_nxt) begin
            w_fwd_rd_nxt   = w_h_rd_nxt;
            w_fwd_data_nxt = w_h_data_nxt;
        end
    end

    // Buffer entries, ready, forwarding and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_valid  <= 1'b0;
            r_h_rd     <= '0;
            r_h_data   <= '0;
            r_s_valid  <= 1'b0;
            r_s_rd     <= '0;
            r_s_data   <= '0;
            r_in_ready <= 1'b0;
            r_fwd_rd   <= '0;
            r_fwd_data <= '0;
            r_retired  <= '0;
        end else begin
            r_h_valid  <= w_h_valid_nxt;
            r_h_rd     <= w_h_rd_nxt;
            r_h_data   <= w_h_data_nxt;
            r_s_valid  <= w_s_valid_nxt;
            r_s_rd     <= w_s_rd_nxt;
            r_s_data   <= w_s_data_nxt;
            r_in_ready <= !w_s_valid_nxt;
            r_fwd_rd   <= w_fwd_rd_nxt;
            r_fwd_data <= w_fwd_data_nxt;
            if (w_retire) begin
                r_retired <= r_retired + RET_W'(1);
            end
        end
    end

    // Architectural flags update at accept time, not at retire time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_carry <= 1'b0;
            r_flag_zero  <= 1'b0;
        end else if (w_accept && in_flags_en) begin
            r_flag_carry <= in_carry;
            r_flag_zero  <= in_zero;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_h_valid;
    assign out_rd     = r_h_rd;
    assign out_data   = r_h_data;
    assign flag_carry = r_flag_carry;
    assign flag_zero  = r_flag_zero;
    assign fwd_valid  = r_h_valid || r_s_valid;
    assign fwd_rd     = r_fwd_rd;
    assign fwd_data   = r_fwd_data;
    assign retired    = r_retired;

endmodule
